multicycle_controller: RTL and testbench

- Multicycle MIPS control unit sitting directly upstream of datapath.
- Consumes opcode/funct fields from the instruction register plus the ALU zero flag, and sequences one instruction over 3-5 states.
- Drives every datapath select/enable: the PC DFF enable, memToReg, pcSrc, aluSrc, regDst, writeEnable, jump and aluControl.
- Also handshakes with a variable-latency unified memory via memReady, and keeps a retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcode/funct
// fields, ALU operations and datapath select values.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTL_W = 4;
    localparam int unsigned SEL_W    = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd5;
    localparam logic [STATE_W-1:0] S_RTYPE_EX = 4'd6;
    localparam logic [STATE_W-1:0] S_ALU_WB   = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd8;
    localparam logic [STATE_W-1:0] S_ADDI_EX  = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDI_WB  = 4'd10;
    localparam logic [STATE_W-1:0] S_JUMP     = 4'd11;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUCTL_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [SEL_W-1:0] ALUB_RT     = 2'b00;
    localparam logic [SEL_W-1:0] ALUB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] ALUB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct to ALU operation decode with a validity flag.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alu_control_c,
    output logic                funct_valid_c
);

    always_comb begin
        alu_control_c = ALU_ADD;
        funct_valid_c = 1'b1;
        case (funct)
            FN_ADD:  alu_control_c = ALU_ADD;
            FN_SUB:  alu_control_c = ALU_SUB;
            FN_AND:  alu_control_c = ALU_AND;
            FN_OR:   alu_control_c = ALU_OR;
            FN_NOR:  alu_control_c = ALU_NOR;
            FN_SLT:  alu_control_c = ALU_SLT;
            default: funct_valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 states,
// handshakes with variable-latency memory and counts retired instructions.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned n = 32,
    parameter int unsigned r = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                memReady,
    output logic                dffEnable,
    output logic                irWrite,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                aluSrcA,
    output logic [SEL_W-1:0]    aluSrc,
    output logic [SEL_W-1:0]    pcSrc,
    output logic                jump,
    output logic                writeEnable,
    output logic [ALUCTL_W-1:0] aluControl,
    output logic                illegal,
    output logic [n-1:0]        retired,
    output logic [STATE_W-1:0]  state
);

    state_t        state_q;
    state_t        state_d;
    logic [n-1:0]  retired_q;
    logic          retire_c;
    logic          op_bne_q;
    logic          op_sw_q;
    logic [ALUCTL_W-1:0] dec_alu_c;
    logic          dec_valid_c;

    // r only mirrors the datapath parameter set
    logic unused_params;
    assign unused_params = (r == 0);

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_control_c (dec_alu_c),
        .funct_valid_c (dec_valid_c)
    );

    // State register and retired counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) begin
                retired_q <= retired_q + n'(1);
            end
        end
    end

    // Opcode flavour captured in DECODE; the IR is not re-read after that
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_bne_q <= 1'b0;
            op_sw_q  <= 1'b0;
        end else if (state_q == S_DECODE) begin
            op_bne_q <= (opcode == OP_BNE);
            op_sw_q  <= (opcode == OP_SW);
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        retire_c    = 1'b0;
        dffEnable   = 1'b0;
        irWrite     = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        aluSrcA     = 1'b0;
        aluSrc      = ALUB_RT;
        pcSrc       = PC_ALU;
        jump        = 1'b0;
        writeEnable = 1'b0;
        aluControl  = ALU_ADD;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrc  = ALUB_FOUR;
                if (memReady) begin
                    irWrite   = 1'b1;
                    dffEnable = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrc = ALUB_IMM_SH;
                case (opcode)
                    OP_RTYPE:      state_d = S_RTYPE_EX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_RTYPE_EX: begin
                aluSrcA = 1'b1;
                if (dec_valid_c) begin
                    aluControl = dec_alu_c;
                end else begin
                    illegal = 1'b1;
                end
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                regDst      = 1'b1;
                writeEnable = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrc  = ALUB_IMM;
                state_d = op_sw_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iorD    = 1'b1;
                memRead = 1'b1;
                if (memReady) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                memToReg    = 1'b1;
                writeEnable = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
                if (memReady) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcSrc      = PC_ALUOUT;
                dffEnable  = op_bne_q ? ~zero : zero;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                aluSrcA = 1'b1;
                aluSrc  = ALUB_IMM;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                writeEnable = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pcSrc     = PC_JUMP;
                jump      = 1'b1;
                dffEnable = 1'b1;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills every strobe at once so no write completes mid-abort
        if (!reset) begin
            dffEnable   = 1'b0;
            irWrite     = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            writeEnable = 1'b0;
            illegal     = 1'b0;
            retire_c    = 1'b0;
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle
// expected controls, a negedge monitor pops and compares them.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    localparam int unsigned N = 4;

    logic         clk;
    logic         reset;
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic         zero;
    logic         memReady;
    logic         dffEnable, irWrite, iorD, memRead, memWrite, memToReg;
    logic         regDst, aluSrcA, jump, writeEnable, illegal;
    logic [1:0]   aluSrc, pcSrc;
    logic [3:0]   aluControl;
    logic [N-1:0] retired;
    logic [3:0]   state;

    multicycle_controller #(.n(N), .r(7)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .memReady(memReady), .dffEnable(dffEnable),
        .irWrite(irWrite), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .memToReg(memToReg), .regDst(regDst),
        .aluSrcA(aluSrcA), .aluSrc(aluSrc), .pcSrc(pcSrc), .jump(jump),
        .writeEnable(writeEnable), .aluControl(aluControl),
        .illegal(illegal), .retired(retired), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dffEnable, irWrite, iorD, memRead, memWrite;
        logic       memToReg, regDst, aluSrcA;
        logic [1:0] aluSrc;
        logic [1:0] pcSrc;
        logic       jump, writeEnable;
        logic [3:0] aluControl;
        logic       illegal;
        logic [3:0] state;
        logic [N-1:0] retired;
    } ctl_t;

    ctl_t  q_v[$];
    ctl_t  q_m[$];
    string q_n[$];
    int    total = 0;
    int    bad   = 0;

    logic [N-1:0] ret_exp;
    logic         g_dec_ill;
    logic         g_bne;
    logic         g_rt_ill;
    logic [3:0]   g_rt_alu;

    // Strobes, jump, state and retired are always checked; other selects only where defined
    function automatic void base_mask(output ctl_t m);
        m = '0;
        m.dffEnable = 1'b1; m.irWrite = 1'b1; m.memRead = 1'b1; m.memWrite = 1'b1;
        m.writeEnable = 1'b1; m.illegal = 1'b1; m.jump = 1'b1;
        m.state = '1; m.retired = '1;
    endfunction

    function automatic void expect_state(input logic [3:0] st, input logic mr,
                                         input logic z, output ctl_t v, output ctl_t m);
        base_mask(m);
        v = '0;
        v.state   = st;
        v.retired = ret_exp;
        case (st)
            S_FETCH: begin
                v.memRead = 1'b1; v.irWrite = mr; v.dffEnable = mr;
                m.iorD = 1'b1; m.aluSrcA = 1'b1; m.aluSrc = '1; m.aluControl = '1; m.pcSrc = '1;
                v.aluSrc = 2'b01; v.aluControl = 4'b0010;
            end
            S_DECODE: begin
                m.aluSrcA = 1'b1; m.aluSrc = '1; m.aluControl = '1;
                v.aluSrc = 2'b11; v.aluControl = 4'b0010; v.illegal = g_dec_ill;
            end
            S_RTYPE_EX: begin
                m.aluSrcA = 1'b1; m.aluSrc = '1; m.aluControl = '1;
                v.aluSrcA = 1'b1; v.aluSrc = 2'b00; v.aluControl = g_rt_alu; v.illegal = g_rt_ill;
            end
            S_ALU_WB: begin
                m.regDst = 1'b1; m.memToReg = 1'b1;
                v.regDst = 1'b1; v.writeEnable = 1'b1;
            end
            S_MEMADR, S_ADDI_EX: begin
                m.aluSrcA = 1'b1; m.aluSrc = '1; m.aluControl = '1;
                v.aluSrcA = 1'b1; v.aluSrc = 2'b10; v.aluControl = 4'b0010;
            end
            S_MEM_RD: begin
                m.iorD = 1'b1; v.iorD = 1'b1; v.memRead = 1'b1;
            end
            S_MEM_WB: begin
                m.regDst = 1'b1; m.memToReg = 1'b1;
                v.memToReg = 1'b1; v.writeEnable = 1'b1;
            end
            S_MEM_WR: begin
                m.iorD = 1'b1; v.iorD = 1'b1; v.memWrite = 1'b1;
            end
            S_BRANCH: begin
                m.aluSrcA = 1'b1; m.aluSrc = '1; m.aluControl = '1; m.pcSrc = '1;
                v.aluSrcA = 1'b1; v.aluSrc = 2'b00; v.aluControl = 4'b0110; v.pcSrc = 2'b01;
                v.dffEnable = g_bne ? ~z : z;
            end
            S_ADDI_WB: begin
                m.regDst = 1'b1; m.memToReg = 1'b1; v.writeEnable = 1'b1;
            end
            S_JUMP: begin
                m.pcSrc = '1; v.pcSrc = 2'b10; v.jump = 1'b1; v.dffEnable = 1'b1;
            end
            default: ;
        endcase
    endfunction

    task automatic push(input ctl_t v, input ctl_t m, input string nm);
        q_v.push_back(v);
        q_m.push_back(m);
        q_n.push_back(nm);
    endtask

    task automatic step(input logic [3:0] st, input logic mr, input logic z, input string nm);
        ctl_t v, m;
        memReady = mr;
        zero     = z;
        expect_state(st, mr, z, v, m);
        push(v, m, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic push_reset(input string nm);
        ctl_t v, m;
        base_mask(m);
        v = '0;
        v.state = S_FETCH;
        push(v, m, nm);
    endtask

    task automatic rst_step(input string nm);
        reset = 1'b0;
        ret_exp = '0;
        push_reset(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits, input string nm);
        for (int i = 0; i < waits; i++) step(S_FETCH, 1'b0, 1'b0, nm);
        step(S_FETCH, 1'b1, 1'b0, nm);
    endtask

    task automatic do_rtype(input logic [5:0] fn, input logic [3:0] alu,
                            input logic ill, input string nm);
        opcode = OP_RTYPE; funct = fn; g_dec_ill = 1'b0;
        g_rt_alu = alu; g_rt_ill = ill;
        fetch(0, nm);
        step(S_DECODE, 1'b1, 1'b0, nm);
        step(S_RTYPE_EX, 1'b1, 1'b0, nm);
        step(S_ALU_WB, 1'b1, 1'b0, nm);
        ret_exp = ret_exp + N'(1);
    endtask

    task automatic do_lw(input int fwait, input int mwait);
        opcode = OP_LW; funct = 6'h15; g_dec_ill = 1'b0;
        fetch(fwait, "lw");
        step(S_DECODE, 1'b1, 1'b0, "lw");
        step(S_MEMADR, 1'b1, 1'b0, "lw");
        for (int i = 0; i < mwait; i++) step(S_MEM_RD, 1'b0, 1'b0, "lw_wait");
        step(S_MEM_RD, 1'b1, 1'b0, "lw");
        step(S_MEM_WB, 1'b1, 1'b0, "lw_wb");
        ret_exp = ret_exp + N'(1);
    endtask

    task automatic do_sw(input int mwait);
        opcode = OP_SW; funct = 6'h2a; g_dec_ill = 1'b0;
        fetch(0, "sw");
        step(S_DECODE, 1'b1, 1'b0, "sw");
        step(S_MEMADR, 1'b1, 1'b0, "sw");
        for (int i = 0; i < mwait; i++) step(S_MEM_WR, 1'b0, 1'b0, "sw_wait");
        step(S_MEM_WR, 1'b1, 1'b0, "sw");
        ret_exp = ret_exp + N'(1);
    endtask

    task automatic do_branch(input logic bne, input logic z, input string nm);
        opcode = bne ? OP_BNE : OP_BEQ; g_bne = bne; g_dec_ill = 1'b0;
        fetch(0, nm);
        step(S_DECODE, 1'b1, 1'b0, nm);
        step(S_BRANCH, 1'b1, z, nm);
        ret_exp = ret_exp + N'(1);
    endtask

    task automatic do_addi();
        opcode = OP_ADDI; g_dec_ill = 1'b0;
        fetch(0, "addi");
        step(S_DECODE, 1'b1, 1'b0, "addi");
        step(S_ADDI_EX, 1'b1, 1'b0, "addi");
        step(S_ADDI_WB, 1'b1, 1'b0, "addi_wb");
        ret_exp = ret_exp + N'(1);
    endtask

    task automatic do_j(input string nm);
        opcode = OP_J; g_dec_ill = 1'b0;
        fetch(0, nm);
        step(S_DECODE, 1'b1, 1'b0, nm);
        step(S_JUMP, 1'b1, 1'b0, nm);
        ret_exp = ret_exp + N'(1);
    endtask

    task automatic do_bad_op(input logic [5:0] op);
        opcode = op; g_dec_ill = 1'b1;
        fetch(0, "bad_op");
        step(S_DECODE, 1'b1, 1'b0, "bad_op_decode");
        g_dec_ill = 1'b0;
        step(S_FETCH, 1'b0, 1'b0, "bad_op_back");
    endtask

    // Monitor: one expected vector per cycle, compared on the falling edge
    always @(negedge clk) begin
        ctl_t act, v, m;
        string nm;
        if (q_v.size() > 0) begin
            v = q_v.pop_front();
            m = q_m.pop_front();
            nm = q_n.pop_front();
            act = '{dffEnable, irWrite, iorD, memRead, memWrite, memToReg, regDst,
                    aluSrcA, aluSrc, pcSrc, jump, writeEnable, aluControl, illegal,
                    state, retired};
            total++;
            if ((act & m) !== (v & m)) begin
                bad++;
                $display("FAIL %s t=%0t: got=%h want=%h mask=%h", nm, $time, act & m, v & m, m);
            end
        end
    end

    initial begin
        reset = 1'b0; memReady = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        ret_exp = '0; g_dec_ill = 1'b0; g_bne = 1'b0; g_rt_ill = 1'b0; g_rt_alu = 4'b0010;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_step("reset_hold");
        reset = 1'b1;

        do_rtype(6'b100000, 4'b0010, 1'b0, "r_add");
        do_rtype(6'b100010, 4'b0110, 1'b0, "r_sub");
        do_rtype(6'b100100, 4'b0000, 1'b0, "r_and");
        do_rtype(6'b100101, 4'b0001, 1'b0, "r_or");
        do_rtype(6'b100111, 4'b1100, 1'b0, "r_nor");
        do_rtype(6'b101010, 4'b0111, 1'b0, "r_slt");
        do_lw(2, 3);
        do_sw(1);
        do_branch(1'b0, 1'b1, "beq_taken");
        do_branch(1'b0, 1'b0, "beq_not");
        do_branch(1'b1, 1'b1, "bne_not");
        do_branch(1'b1, 1'b0, "bne_taken");
        do_addi();
        do_bad_op(6'b111111);
        do_rtype(6'b000000, 4'b0010, 1'b1, "r_bad_funct");

        for (int i = 0; i < 20 && ret_exp != '1; i++) do_j("j_preload");
        do_j("j_wrap");

        // Abort a store mid-access: reset falls between edges
        opcode = OP_SW; g_dec_ill = 1'b0;
        fetch(0, "sw_abort");
        step(S_DECODE, 1'b1, 1'b0, "sw_abort");
        step(S_MEMADR, 1'b1, 1'b0, "sw_abort");
        step(S_MEM_WR, 1'b0, 1'b0, "sw_abort_memwr");
        memReady = 1'b0;
        #2;
        reset = 1'b0;
        ret_exp = '0;
        push_reset("rst_mid_memwr");
        @(posedge clk);
        #1;
        rst_step("rst_mid_hold");
        reset = 1'b1;
        do_j("j_after_rst");

        repeat (2) @(posedge clk);
        total++;
        if (q_v.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got=%0d pending want=0", q_v.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
